// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM for the RV32IM core.
// Optional wait-state timeout fault enabled by defining SEQ_TIMEOUT_EN.
module core_sequencer #(
   parameter logic [1:0]  DEST_MEM       = 2'd1,
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned TMO_W          = 9
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   output logic       imem_req_o,
   input  logic       imem_ready_i,
   output logic       ir_load_o,
   input  logic       br_sig_i,
   input  logic       reg_wr_sig_i,
   input  logic       mem_wr_sig_i,
   input  logic [1:0] data_dest_i,
   output logic       alu_start_o,
   input  logic       alu_done_i,
   output logic       dmem_req_o,
   output logic       dmem_we_o,
   input  logic       dmem_ready_i,
   output logic       reg_wr_en_o,
   output logic       pc_wr_en_o,
   output logic       retire_o,
   input  logic       halt_req_i,
   output logic       halted_o,
   output logic       err_o,
   output logic [2:0] state_o
);

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEMORY    = 3'd3,
      S_WRITEBACK = 3'd4,
      S_HALTED    = 3'd5
   } state_t;

   state_t state_q, state_d;

   logic mem_q;
   logic st_q;
   logic wr_q;
   logic br_q;
   logic started_q;
   logic stall;
   logic tmo;
   logic err_q;

   // Branch flag is captured for next-PC selection outside this block
   logic unused_br;
   assign unused_br = br_q;

   always_comb begin
      stall = 1'b0;
      unique case (state_q)
         S_FETCH:   stall = ~imem_ready_i;
         S_EXECUTE: stall = ~alu_done_i;
         S_MEMORY:  stall = ~dmem_ready_i;
         default:   stall = 1'b0;
      endcase
   end

   always_comb begin
      state_d = S_FETCH;
      unique case (state_q)
         S_FETCH: begin
            state_d = imem_ready_i ? S_DECODE : S_FETCH;
         end
         S_DECODE: begin
            state_d = S_EXECUTE;
         end
         S_EXECUTE: begin
            if (alu_done_i) begin
               state_d = mem_q ? S_MEMORY : S_WRITEBACK;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_MEMORY: begin
            state_d = dmem_ready_i ? S_WRITEBACK : S_MEMORY;
         end
         S_WRITEBACK: begin
            state_d = halt_req_i ? S_HALTED : S_FETCH;
         end
         S_HALTED: begin
            state_d = (halt_req_i || err_q) ? S_HALTED : S_FETCH;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
      if (tmo) begin
         state_d = S_HALTED;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= S_FETCH;
         mem_q     <= 1'b0;
         st_q      <= 1'b0;
         wr_q      <= 1'b0;
         br_q      <= 1'b0;
         started_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         // High from the second EXECUTE cycle on, so start is a single strobe
         started_q <= (state_q == S_EXECUTE) && (state_d == S_EXECUTE);
         if (state_q == S_DECODE) begin
            mem_q <= (data_dest_i == DEST_MEM);
            st_q  <= mem_wr_sig_i;
            wr_q  <= reg_wr_sig_i & ~mem_wr_sig_i;
            br_q  <= br_sig_i;
         end
      end
   end

`ifdef SEQ_TIMEOUT_EN
   localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(TIMEOUT_CYCLES - 1);

   logic [TMO_W-1:0] cnt_q;

   // Fault on the last allowed wait cycle unless the state is about to move on
   assign tmo = stall && (cnt_q == TMO_LIM);

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_d != state_q) begin
            cnt_q <= '0;
         end else if (stall) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (tmo) begin
            err_q <= 1'b1;
         end
      end
   end
`else
   localparam int unsigned unused_tmo_cfg = TIMEOUT_CYCLES + TMO_W;

   logic unused_stall;
   assign unused_stall = stall;
   assign tmo          = 1'b0;
   assign err_q        = 1'b0;
`endif

   always_comb begin
      imem_req_o  = 1'b0;
      ir_load_o   = 1'b0;
      alu_start_o = 1'b0;
      dmem_req_o  = 1'b0;
      dmem_we_o   = 1'b0;
      reg_wr_en_o = 1'b0;
      pc_wr_en_o  = 1'b0;
      retire_o    = 1'b0;
      halted_o    = 1'b0;
      if (rst_n_i) begin
         unique case (state_q)
            S_FETCH: begin
               imem_req_o = 1'b1;
               ir_load_o  = imem_ready_i;
            end
            S_EXECUTE: begin
               alu_start_o = ~started_q;
            end
            S_MEMORY: begin
               dmem_req_o = 1'b1;
               dmem_we_o  = st_q;
            end
            S_WRITEBACK: begin
               reg_wr_en_o = wr_q;
               pc_wr_en_o  = 1'b1;
               retire_o    = 1'b1;
            end
            S_HALTED: begin
               halted_o = 1'b1;
            end
            default: begin
               halted_o = 1'b0;
            end
         endcase
      end
   end

   assign err_o   = rst_n_i & err_q;
   assign state_o = rst_n_i ? state_q : 3'd0;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed, table-driven bench for core_sequencer.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_core_sequencer;

   localparam logic [9:0] O_IREQ = 10'b1000000000;
   localparam logic [9:0] O_IRL  = 10'b0100000000;
   localparam logic [9:0] O_AS   = 10'b0010000000;
   localparam logic [9:0] O_DREQ = 10'b0001000000;
   localparam logic [9:0] O_DWE  = 10'b0000100000;
   localparam logic [9:0] O_RWE  = 10'b0000010000;
   localparam logic [9:0] O_PC   = 10'b0000001000;
   localparam logic [9:0] O_RET  = 10'b0000000100;
   localparam logic [9:0] O_HLT  = 10'b0000000010;
   localparam logic [9:0] O_ERR  = 10'b0000000001;
   localparam logic [9:0] O_NONE = 10'b0000000000;

`ifdef SEQ_TIMEOUT_EN
   localparam int unsigned TMO    = 8;
   localparam int          DIV_LAT = 6;
`else
   localparam int unsigned TMO    = 256;
   localparam int          DIV_LAT = 33;
`endif

   logic       clk;
   logic       rst_n;
   logic       imem_req;
   logic       imem_ready;
   logic       ir_load;
   logic       br_sig;
   logic       reg_wr_sig;
   logic       mem_wr_sig;
   logic [1:0] data_dest;
   logic       alu_start;
   logic       alu_done;
   logic       dmem_req;
   logic       dmem_we;
   logic       dmem_ready;
   logic       reg_wr_en;
   logic       pc_wr_en;
   logic       retire;
   logic       halt_req;
   logic       halted;
   logic       err;
   logic [2:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   core_sequencer #(
      .DEST_MEM      (2'd1),
      .TIMEOUT_CYCLES(TMO),
      .TMO_W         (9)
   ) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .imem_req_o  (imem_req),
      .imem_ready_i(imem_ready),
      .ir_load_o   (ir_load),
      .br_sig_i    (br_sig),
      .reg_wr_sig_i(reg_wr_sig),
      .mem_wr_sig_i(mem_wr_sig),
      .data_dest_i (data_dest),
      .alu_start_o (alu_start),
      .alu_done_i  (alu_done),
      .dmem_req_o  (dmem_req),
      .dmem_we_o   (dmem_we),
      .dmem_ready_i(dmem_ready),
      .reg_wr_en_o (reg_wr_en),
      .pc_wr_en_o  (pc_wr_en),
      .retire_o    (retire),
      .halt_req_i  (halt_req),
      .halted_o    (halted),
      .err_o       (err),
      .state_o     (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       rst_n;
      logic       irdy;
      logic       br;
      logic       regwr;
      logic       memwr;
      logic [1:0] dest;
      logic       done;
      logic       drdy;
      logic       halt;
      logic [2:0] st;
      logic [9:0] o;
   } vec_t;

   function automatic vec_t mk(
      input string nm, input logic r, input logic ir, input logic b,
      input logic rw, input logic mw, input logic [1:0] d,
      input logic dn, input logic dr, input logic h,
      input logic [2:0] s, input logic [9:0] o);
      vec_t v;
      v.name = nm; v.rst_n = r; v.irdy = ir; v.br = b;
      v.regwr = rw; v.memwr = mw; v.dest = d;
      v.done = dn; v.drdy = dr; v.halt = h;
      v.st = s; v.o = o;
      return v;
   endfunction

   task automatic apply(input vec_t v);
      logic [9:0] got;
      @(negedge clk);
      rst_n      = v.rst_n;
      imem_ready = v.irdy;
      br_sig     = v.br;
      reg_wr_sig = v.regwr;
      mem_wr_sig = v.memwr;
      data_dest  = v.dest;
      alu_done   = v.done;
      dmem_ready = v.drdy;
      halt_req   = v.halt;
      #1;
      got = {imem_req, ir_load, alu_start, dmem_req, dmem_we,
             reg_wr_en, pc_wr_en, retire, halted, err};
      n_checks++;
      if (state !== v.st) begin
         n_fail++;
         $display("FAIL %s state: got %0d want %0d", v.name, state, v.st);
      end
      n_checks++;
      if (got !== v.o) begin
         n_fail++;
         $display("FAIL %s outs: got %b want %b", v.name, got, v.o);
      end
   endtask

   vec_t tbl[$];

   initial begin
      rst_n = 1'b0; imem_ready = 1'b0; br_sig = 1'b0;
      reg_wr_sig = 1'b0; mem_wr_sig = 1'b0; data_dest = 2'd0;
      alu_done = 1'b0; dmem_ready = 1'b0; halt_req = 1'b0;

      // Reset with busy inputs, then ADDI, stalled-fetch LW, SW
      tbl.push_back(mk("rst0",   0,1,0,1,0,2'd0,1,1,1, 3'd0, O_NONE));
      tbl.push_back(mk("rst1",   0,1,0,1,0,2'd0,1,1,0, 3'd0, O_NONE));
      tbl.push_back(mk("addi_f", 1,1,0,1,0,2'd0,1,1,0, 3'd0, O_IREQ|O_IRL));
      tbl.push_back(mk("addi_d", 1,1,0,1,0,2'd0,1,1,0, 3'd1, O_NONE));
      tbl.push_back(mk("addi_e", 1,1,0,1,0,2'd0,1,1,0, 3'd2, O_AS));
      tbl.push_back(mk("addi_w", 1,1,0,1,0,2'd0,1,1,0, 3'd4, O_RWE|O_PC|O_RET));
      tbl.push_back(mk("lw_fw0", 1,0,0,1,0,2'd1,1,1,0, 3'd0, O_IREQ));
      tbl.push_back(mk("lw_fw1", 1,0,0,1,0,2'd1,1,1,0, 3'd0, O_IREQ));
      tbl.push_back(mk("lw_f",   1,1,0,1,0,2'd1,0,0,0, 3'd0, O_IREQ|O_IRL));
      tbl.push_back(mk("lw_d",   1,1,0,1,0,2'd1,0,0,0, 3'd1, O_NONE));
      tbl.push_back(mk("lw_e",   1,1,0,1,0,2'd1,1,0,0, 3'd2, O_AS));
      tbl.push_back(mk("lw_m0",  1,1,0,1,0,2'd1,1,0,0, 3'd3, O_DREQ));
      tbl.push_back(mk("lw_m1",  1,1,0,1,0,2'd1,1,0,0, 3'd3, O_DREQ));
      tbl.push_back(mk("lw_m2",  1,1,0,1,0,2'd1,1,0,0, 3'd3, O_DREQ));
      tbl.push_back(mk("lw_m3",  1,1,0,1,0,2'd1,1,1,0, 3'd3, O_DREQ));
      tbl.push_back(mk("lw_w",   1,1,0,1,0,2'd1,1,1,0, 3'd4, O_RWE|O_PC|O_RET));
      tbl.push_back(mk("sw_f",   1,1,0,1,1,2'd1,1,1,0, 3'd0, O_IREQ|O_IRL));
      tbl.push_back(mk("sw_d",   1,1,0,1,1,2'd1,1,1,0, 3'd1, O_NONE));
      tbl.push_back(mk("sw_e",   1,1,0,1,1,2'd1,1,1,0, 3'd2, O_AS));
      tbl.push_back(mk("sw_m",   1,1,0,1,1,2'd1,1,1,0, 3'd3, O_DREQ|O_DWE));
      tbl.push_back(mk("sw_w",   1,1,0,1,1,2'd1,1,1,0, 3'd4, O_PC|O_RET));
      foreach (tbl[i]) apply(tbl[i]);

      // DIV: long ALU latency with stray dmem_ready
      apply(mk("div_f", 1,1,0,1,0,2'd0,0,1,0, 3'd0, O_IREQ|O_IRL));
      apply(mk("div_d", 1,0,0,1,0,2'd0,0,1,0, 3'd1, O_NONE));
      for (int i = 0; i < DIV_LAT; i++) begin
         apply(mk("div_e", 1,1,0,1,0,2'd0, (i == DIV_LAT-1), 1, 0,
                  3'd2, (i == 0) ? O_AS : O_NONE));
      end
      apply(mk("div_w", 1,0,0,1,0,2'd0,0,1,0, 3'd4, O_RWE|O_PC|O_RET));

      // Halt raised mid-EXECUTE: instruction retires, then HALTED
      apply(mk("hlt_f",  1,1,1,0,0,2'd0,0,0,0, 3'd0, O_IREQ|O_IRL));
      apply(mk("hlt_d",  1,0,1,0,0,2'd0,0,0,0, 3'd1, O_NONE));
      apply(mk("hlt_e0", 1,0,1,0,0,2'd0,0,0,0, 3'd2, O_AS));
      apply(mk("hlt_e1", 1,0,1,0,0,2'd0,0,0,1, 3'd2, O_NONE));
      apply(mk("hlt_e2", 1,0,1,0,0,2'd0,1,0,1, 3'd2, O_NONE));
      apply(mk("hlt_w",  1,0,1,0,0,2'd0,0,0,1, 3'd4, O_PC|O_RET));
      apply(mk("hlt_h0", 1,1,0,0,0,2'd0,1,1,1, 3'd5, O_HLT));
      apply(mk("hlt_h1", 1,1,0,0,0,2'd0,1,1,1, 3'd5, O_HLT));
      apply(mk("hlt_h2", 1,0,0,0,0,2'd0,0,0,0, 3'd5, O_HLT));
      apply(mk("hlt_f2", 1,0,0,0,0,2'd0,0,0,0, 3'd0, O_IREQ));

      // Reset while a load waits in MEMORY
      apply(mk("rm_f",  1,1,0,1,0,2'd1,0,0,0, 3'd0, O_IREQ|O_IRL));
      apply(mk("rm_d",  1,0,0,1,0,2'd1,0,0,0, 3'd1, O_NONE));
      apply(mk("rm_e",  1,0,0,1,0,2'd1,1,0,0, 3'd2, O_AS));
      apply(mk("rm_m",  1,0,0,1,0,2'd1,1,0,0, 3'd3, O_DREQ));
      apply(mk("rm_r",  0,0,0,1,0,2'd1,1,0,0, 3'd0, O_NONE));
      apply(mk("rm_f2", 1,0,0,0,0,2'd0,1,1,0, 3'd0, O_IREQ));
      apply(mk("rm_f3", 1,1,0,0,0,2'd0,1,1,0, 3'd0, O_IREQ|O_IRL));
      apply(mk("rm_d3", 1,0,0,0,0,2'd0,1,1,0, 3'd1, O_NONE));
      apply(mk("rm_e3", 1,0,0,0,0,2'd0,1,1,0, 3'd2, O_AS));
      apply(mk("rm_w3", 1,0,0,0,0,2'd0,1,1,0, 3'd4, O_PC|O_RET));

`ifdef SEQ_TIMEOUT_EN
      // Stuck fetch: fault after TMO wait cycles, sticky until reset
      apply(mk("to_rst", 0,0,0,0,0,2'd0,0,0,0, 3'd0, O_NONE));
      for (int i = 0; i < int'(TMO); i++) begin
         apply(mk("to_fw", 1,0,0,0,0,2'd0,0,0,0, 3'd0, O_IREQ));
      end
      for (int i = 0; i < 3; i++) begin
         apply(mk("to_h", 1,1,0,0,0,2'd0,1,1,0, 3'd5, O_HLT|O_ERR));
      end
      apply(mk("to_r",  0,0,0,0,0,2'd0,0,0,0, 3'd0, O_NONE));
      apply(mk("to_f",  1,0,0,0,0,2'd0,0,0,0, 3'd0, O_IREQ));
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
